// File: rtl/sd_bus_arbiter.sv
// Arbitrates the SPI-mode SD pads between the init, read and write engines,
// inserting a CS-high gap between owners. Define SD_ARB_STATS_EN for completion counters.
module sd_bus_arbiter #(
  parameter int GAP_CLKS = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic        SD_CK,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic        init_done,
  input  logic        init_mosi,
  input  logic        init_csn,
  input  logic        rd_req,
  input  logic        rd_done,
  input  logic        rd_mosi,
  input  logic        rd_csn,
  input  logic        wr_req,
  input  logic        wr_done,
  input  logic        wr_mosi,
  input  logic        wr_csn,
  output logic        init_gnt,
  output logic        rd_gnt,
  output logic        wr_gnt,
  output logic        SD_MOSI,
  output logic        SD_CSn,
  output logic        card_ready,
  output logic        busy,
`ifdef SD_ARB_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
  typedef enum logic [1:0] {OWN_INIT, OWN_RD, OWN_WR} owner_e;

  localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [7:0]      GAP_LOAD = 8'(GAP_CLKS - 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      gap_q, gap_d;

  logic own_req, own_done, own_mosi, own_csn, in_grant, wd_hit;

  // Owner-side view of the engine signals, selected by the registered owner.
  always_comb begin
    own_req  = init_req;
    own_done = init_done;
    own_mosi = init_mosi;
    own_csn  = init_csn;
    case (owner_q)
      OWN_RD: begin
        own_req  = rd_req;
        own_done = rd_done;
        own_mosi = rd_mosi;
        own_csn  = rd_csn;
      end
      OWN_WR: begin
        own_req  = wr_req;
        own_done = wr_done;
        own_mosi = wr_mosi;
        own_csn  = wr_csn;
      end
      default: ;
    endcase
  end

  assign wd_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rdy_d   = rdy_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (!rdy_q) begin
          if (init_req) begin
            owner_d = OWN_INIT;
            state_d = GRANT;
          end
        end else if (rd_req && (!wr_req || last_q != OWN_RD)) begin
          owner_d = OWN_RD;
          state_d = GRANT;
        end else if (wr_req) begin
          owner_d = OWN_WR;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (TIMEOUT != 0) wd_d = wd_q + 1'b1;
        // done beats req-drop beats watchdog; only a pure timeout raises err
        if (own_done || !own_req || wd_hit) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
          if (owner_q != OWN_INIT) last_d = owner_q;
          if (own_done) begin
            if (owner_q == OWN_INIT) rdy_d = 1'b1;
          end else if (own_req) begin
            err_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_INIT;
      last_q  <= OWN_WR;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign in_grant    = (state_q == GRANT);
  assign init_gnt    = in_grant && (owner_q == OWN_INIT);
  assign rd_gnt      = in_grant && (owner_q == OWN_RD);
  assign wr_gnt      = in_grant && (owner_q == OWN_WR);
  assign SD_MOSI     = in_grant ? own_mosi : 1'b1;
  assign SD_CSn      = in_grant ? own_csn  : 1'b1;
  assign card_ready  = rdy_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

`ifdef SD_ARB_STATS_EN
  logic [15:0] rdc_q, wrc_q;
  logic        rd_inc, wr_inc;

  assign rd_inc = rd_gnt && rd_done;
  assign wr_inc = wr_gnt && wr_done;

  always_ff @(negedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      rdc_q <= '0;
      wrc_q <= '0;
    end else begin
      if (rd_inc) rdc_q <= rdc_q + 16'd1;
      if (wr_inc) wrc_q <= wrc_q + 16'd1;
    end
  end

  assign rd_count = rdc_q;
  assign wr_count = wrc_q;
`endif

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Scoreboard bench for sd_bus_arbiter: directed scenarios plus a random phase,
// checked against an event-timeline reference model.
module tb_sd_bus_arbiter;
  localparam int G = 8;
  localparam int T = 16;

  typedef struct packed {
    bit rst;
    bit ireq, idone, imosi, icsn;
    bit rreq, rdone, rmosi, rcsn;
    bit wreq, wdone, wmosi, wcsn;
  } stim_t;

  typedef struct packed {
    logic [2:0]  gnt;
    logic        mosi, csn, rdy, busy, err;
    logic [15:0] rdc, wrc;
  } exp_t;

  logic SD_CK = 1'b1;
  logic rst_n = 1'b0;
  logic init_req = 1'b0, init_done = 1'b0, init_mosi = 1'b1, init_csn = 1'b1;
  logic rd_req = 1'b0, rd_done = 1'b0, rd_mosi = 1'b1, rd_csn = 1'b1;
  logic wr_req = 1'b0, wr_done = 1'b0, wr_mosi = 1'b1, wr_csn = 1'b1;
  logic init_gnt, rd_gnt, wr_gnt, SD_MOSI, SD_CSn, card_ready, busy, err_timeout;
`ifdef SD_ARB_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  sd_bus_arbiter #(.GAP_CLKS(G), .TIMEOUT(T)) dut (
    .SD_CK(SD_CK), .rst_n(rst_n),
    .init_req(init_req), .init_done(init_done), .init_mosi(init_mosi), .init_csn(init_csn),
    .rd_req(rd_req), .rd_done(rd_done), .rd_mosi(rd_mosi), .rd_csn(rd_csn),
    .wr_req(wr_req), .wr_done(wr_done), .wr_mosi(wr_mosi), .wr_csn(wr_csn),
    .init_gnt(init_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .SD_MOSI(SD_MOSI), .SD_CSn(SD_CSn), .card_ready(card_ready), .busy(busy),
`ifdef SD_ARB_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .err_timeout(err_timeout)
  );

  always #5 SD_CK = ~SD_CK;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  // Reference model as a timeline: mode 0 idle, 1 owned, 2 gap; owner 0 init, 1 rd, 2 wr.
  int          edge_n = 0, m_gedge = 0, m_gap_end = 0;
  int          m_mode = 0, m_own = 0, m_last = 2;
  bit          m_rdy = 0, m_err = 0;
  logic [15:0] m_rdc = 0, m_wrc = 0;

  function automatic int age();
    return edge_n - m_gedge;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_last = 2; m_rdy = 0; m_err = 0; m_rdc = 0; m_wrc = 0;
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t e;
    bit   mo[3], cs[3];
    mo[0] = s.imosi; mo[1] = s.rmosi; mo[2] = s.wmosi;
    cs[0] = s.icsn;  cs[1] = s.rcsn;  cs[2] = s.wcsn;
    e.gnt  = (m_mode == 1) ? 3'(1 << m_own) : 3'b000;
    e.mosi = (m_mode == 1) ? mo[m_own] : 1'b1;
    e.csn  = (m_mode == 1) ? cs[m_own] : 1'b1;
    e.rdy  = m_rdy;
    e.busy = (m_mode != 0);
    e.err  = m_err;
    e.rdc  = m_rdc;
    e.wrc  = m_wrc;
    return e;
  endfunction

  function automatic void model_edge(stim_t s);
    bit req[3], dn[3];
    bit nerr = 1'b0;
    int pick = -1;
    req[0] = s.ireq;  req[1] = s.rreq;  req[2] = s.wreq;
    dn[0]  = s.idone; dn[1]  = s.rdone; dn[2]  = s.wdone;
    if (!s.rst) begin
      edge_n++;
      return;
    end
    if (m_mode == 0) begin
      if (!m_rdy)                pick = req[0] ? 0 : -1;
      else if (req[1] && req[2]) pick = 3 - m_last;
      else if (req[1])           pick = 1;
      else if (req[2])           pick = 2;
      if (pick >= 0) begin
        m_mode = 1; m_own = pick; m_gedge = edge_n;
      end
    end else if (m_mode == 1) begin
      if (dn[m_own] || !req[m_own] || (age() == T)) begin
        if (dn[m_own]) begin
          if (m_own == 0) m_rdy = 1'b1;
          if (m_own == 1) m_rdc = m_rdc + 16'd1;
          if (m_own == 2) m_wrc = m_wrc + 16'd1;
        end else if (req[m_own]) begin
          nerr = 1'b1;
        end
        if (m_own != 0) m_last = m_own;
        m_mode = 2; m_gap_end = edge_n + G;
      end
    end else if (edge_n == m_gap_end) begin
      m_mode = 0;
    end
    m_err = nerr;
    edge_n++;
  endfunction

  function automatic stim_t mk(bit ir, bit id, bit rr, bit rd, bit wr, bit wd);
    stim_t s;
    s.rst = 1'b1;
    s.ireq = ir; s.idone = id; s.rreq = rr; s.rdone = rd; s.wreq = wr; s.wdone = wd;
    s.imosi = 1'($urandom_range(1)); s.icsn = 1'($urandom_range(1));
    s.rmosi = 1'($urandom_range(1)); s.rcsn = 1'($urandom_range(1));
    s.wmosi = 1'($urandom_range(1)); s.wcsn = 1'($urandom_range(1));
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge SD_CK);
    rst_n = s.rst;
    init_req = s.ireq; init_done = s.idone; init_mosi = s.imosi; init_csn = s.icsn;
    rd_req = s.rreq;   rd_done = s.rdone;   rd_mosi = s.rmosi;   rd_csn = s.rcsn;
    wr_req = s.wreq;   wr_done = s.wdone;   wr_mosi = s.wmosi;   wr_csn = s.wcsn;
    #1;
    if (!s.rst) model_reset();
    e = model_out(s);
    sb.push_back(e);
    model_edge(s);
  endtask

  task automatic idle(input int n);
    repeat (n) step(mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_init();
    stim_t s;
    for (int i = 0; i < 40; i++) begin
      s = mk(1, 0, 0, 0, 0, 0);
      if (m_mode == 1 && m_own == 0 && age() == 3) s.idone = 1'b1;
      step(s);
      if (m_rdy) break;
    end
    idle(G + 3);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge SD_CK);
      #2;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt", 16'({wr_gnt, rd_gnt, init_gnt}), 16'(e.gnt));
        chk("pads", 16'({SD_MOSI, SD_CSn}), 16'({e.mosi, e.csn}));
        chk("status", 16'({card_ready, busy, err_timeout}), 16'({e.rdy, e.busy, e.err}));
`ifdef SD_ARB_STATS_EN
        chk("rd_count", rd_count, e.rdc);
        chk("wr_count", wr_count, e.wrc);
`endif
      end
    end
  end

  initial begin
    stim_t s;
    bit ir = 0, rr = 0, wr = 0;

    // Reset, then rd_req before init must be ignored; init handshake follows.
    s = mk(0, 0, 1, 0, 0, 0); s.rst = 1'b0;
    repeat (2) step(s);
    repeat (4) step(mk(0, 0, 1, 0, 0, 0));
    do_init();

    // Both requesters held: alternate RD/WR, each finishing after 5 cycles.
    for (int i = 0; i < 70; i++) begin
      s = mk(0, 0, 1, 0, 1, 0);
      if (m_mode == 1 && age() == 5) begin
        if (m_own == 1) s.rdone = 1'b1;
        else            s.wdone = 1'b1;
      end
      step(s);
    end
    idle(G + 4);

    // Write owner never finishes: watchdog revokes it.
    repeat (T + G + 6) step(mk(0, 0, 0, 0, 1, 0));
    idle(G + 4);

    // Read owner aborts by dropping its request.
    repeat (4) step(mk(0, 0, 1, 0, 0, 0));
    idle(G + 4);

    // rd_done coincides with the watchdog; a stray wr_done mid-transfer.
    for (int i = 0; i < T + G + 4; i++) begin
      s = mk(0, 0, 1, 0, 0, 0);
      if (m_mode == 1 && m_own == 1) begin
        if (age() == T) s.rdone = 1'b1;
        if (age() == 3) s.wdone = 1'b1;
      end
      step(s);
    end
    idle(G + 4);

    // Random traffic with stray done pulses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ir = !ir;
      if ($urandom_range(7) == 0) rr = !rr;
      if ($urandom_range(7) == 0) wr = !wr;
      s = mk(ir, $urandom_range(11) == 0, rr, $urandom_range(11) == 0,
             wr, $urandom_range(11) == 0);
      if ($urandom_range(499) == 0) s.rst = 1'b0;
      step(s);
    end

    // Reset during a WR grant; afterwards wr_req alone must not be granted.
    s = mk(0, 0, 0, 0, 0, 0); s.rst = 1'b0;
    step(s);
    do_init();
    repeat (4) step(mk(0, 0, 0, 0, 1, 0));
    s = mk(0, 0, 0, 0, 1, 0); s.rst = 1'b0;
    repeat (2) step(s);
    repeat (10) step(mk(0, 0, 0, 0, 1, 0));

    repeat (2) @(posedge SD_CK);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
